// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multicycle Moore sequencer for a 16-bit ISA. Fetches one word
//               from instruction memory, decodes it, and drives the register
//               file, data memory and ALU controls for one execute step
//               (two steps for LOAD). Outputs depend on state and IR only.
//
// Ports       : CLK        - clock, rising edge
//               RST        - synchronous active-high reset
//               IM_data    - instruction word at PC_addr (sampled in FETCH)
//               PC_addr    - instruction-memory address
//               IR         - instruction register
//               state      - current FSM state (debug)
//               D_addr     - data-memory address
//               D_wr       - data-memory write strobe
//               RF_s       - write-back select (0 ALU, 1 memory, 2 immediate)
//               RF_W_addr  - register-file write address
//               RF_W_wr    - register-file write enable
//               RF_Ra_addr - register-file port A read address
//               RF_Rb_addr - register-file port B read address
//               ALU_s0     - ALU op (0 pass, 1 ADD, 2 SUB)
//               imm        - 8-bit immediate (only when CU_LDI_EN is defined)
//
// Build option: define CU_LDI_EN to add the LDI instruction (op 0110) and the
//               imm output. Without it, op 0110 executes as NOOP.
//
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int PC_W    = 7,
    parameter int DADDR_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [15:0]        IM_data,
`ifdef CU_LDI_EN
    output logic [7:0]         imm,
`endif
    output logic [PC_W-1:0]    PC_addr,
    output logic [15:0]        IR,
    output logic [3:0]         state,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic [1:0]         RF_s,
    output logic [3:0]         RF_W_addr,
    output logic               RF_W_wr,
    output logic [3:0]         RF_Ra_addr,
    output logic [3:0]         RF_Rb_addr,
    output logic [2:0]         ALU_s0
);

    localparam logic [3:0] c_S_INIT   = 4'd0;
    localparam logic [3:0] c_S_FETCH  = 4'd1;
    localparam logic [3:0] c_S_DECODE = 4'd2;
    localparam logic [3:0] c_S_NOOP   = 4'd3;
    localparam logic [3:0] c_S_LOAD_A = 4'd4;
    localparam logic [3:0] c_S_LOAD_B = 4'd5;
    localparam logic [3:0] c_S_STORE  = 4'd6;
    localparam logic [3:0] c_S_ADD    = 4'd7;
    localparam logic [3:0] c_S_SUB    = 4'd8;
    localparam logic [3:0] c_S_HALT   = 4'd9;
    localparam logic [3:0] c_S_LDI    = 4'd10;

    localparam logic [3:0] c_OP_STORE = 4'h1;
    localparam logic [3:0] c_OP_LOAD  = 4'h2;
    localparam logic [3:0] c_OP_ADD   = 4'h3;
    localparam logic [3:0] c_OP_SUB   = 4'h4;
    localparam logic [3:0] c_OP_HALT  = 4'h5;
    localparam logic [3:0] c_OP_LDI   = 4'h6;

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [3:0]      w_op;

    assign w_op    = r_ir[15:12];
    assign PC_addr = r_pc;
    assign IR      = r_ir;
    assign state   = r_state;

    // State, PC and IR. PC/IR only move in FETCH; PC wraps naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_S_FETCH) begin
                r_ir <= IM_data;
                r_pc <= r_pc + c_PC_ONE;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = c_S_FETCH;
        case (r_state)
            c_S_INIT:   w_next = c_S_FETCH;
            c_S_FETCH:  w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (w_op)
                    c_OP_STORE: w_next = c_S_STORE;
                    c_OP_LOAD:  w_next = c_S_LOAD_A;
                    c_OP_ADD:   w_next = c_S_ADD;
                    c_OP_SUB:   w_next = c_S_SUB;
                    c_OP_HALT:  w_next = c_S_HALT;
`ifdef CU_LDI_EN
                    c_OP_LDI:   w_next = c_S_LDI;
`else
                    c_OP_LDI:   w_next = c_S_NOOP;
`endif
                    default:    w_next = c_S_NOOP;
                endcase
            end
            c_S_LOAD_A: w_next = c_S_LOAD_B;
            c_S_HALT:   w_next = c_S_HALT;
            default:    w_next = c_S_FETCH;
        endcase
    end

    // Moore outputs: everything idles at zero unless an execute state
    // claims it. Write strobes only ever appear in execute states.
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 2'd0;
        RF_W_addr  = 4'd0;
        RF_W_wr    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s0     = 3'd0;
`ifdef CU_LDI_EN
        imm        = 8'd0;
`endif
        case (r_state)
            c_S_STORE: begin
                D_addr     = DADDR_W'(r_ir[11:4]);
                RF_Ra_addr = r_ir[3:0];
                D_wr       = 1'b1;
            end
            // LOAD_A spends one cycle waiting on the synchronous memory read
            // with the write-back path already steered; LOAD_B commits it.
            c_S_LOAD_A, c_S_LOAD_B: begin
                D_addr    = DADDR_W'(r_ir[11:4]);
                RF_s      = 2'd1;
                RF_W_addr = r_ir[3:0];
                RF_W_wr   = (r_state == c_S_LOAD_B);
            end
            c_S_ADD, c_S_SUB: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                RF_W_addr  = r_ir[3:0];
                ALU_s0     = (r_state == c_S_ADD) ? 3'd1 : 3'd2;
                RF_W_wr    = 1'b1;
            end
`ifdef CU_LDI_EN
            c_S_LDI: begin
                imm       = r_ir[11:4];
                RF_s      = 2'd2;
                RF_W_addr = r_ir[3:0];
                RF_W_wr   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Instruction memory is
//               an array indexed by PC_addr; an instruction-level model
//               expands each fetched word into its expected per-cycle outputs.
//               Build with CU_LDI_EN to cover the LDI variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  daddr;
        logic        dwr;
        logic [1:0]  rfs;
        logic [3:0]  wa;
        logic        wwr;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic [7:0]  imm;
    } obs_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] IM_data;
    logic [6:0]  PC_addr;
    logic [15:0] IR;
    logic [3:0]  state;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [1:0]  RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
`ifdef CU_LDI_EN
    logic [7:0]  imm;
`endif

    logic [15:0] im [0:127];
    assign IM_data = im[PC_addr];

    always #5 CLK = ~CLK;

    control_unit #(.PC_W(7), .DADDR_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IM_data    (IM_data),
`ifdef CU_LDI_EN
        .imm        (imm),
`endif
        .PC_addr    (PC_addr),
        .IR         (IR),
        .state      (state),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [6:0]  m_pc;
    logic [15:0] m_ir;

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state;  o.pc = PC_addr; o.ir = IR;
        o.daddr = D_addr; o.dwr = D_wr; o.rfs = RF_s;
        o.wa = RF_W_addr; o.wwr = RF_W_wr;
        o.ra = RF_Ra_addr; o.rb = RF_Rb_addr; o.alu = ALU_s0;
`ifdef CU_LDI_EN
        o.imm = imm;
`else
        o.imm = 8'h00;
`endif
        return o;
    endfunction

    // Idle record for a given state: only state/PC/IR are non-zero.
    function automatic obs_t rec(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st; e.pc = m_pc; e.ir = m_ir;
        return e;
    endfunction

    task automatic chk(input string tag, input obs_t e);
        obs_t o;
        o = get_obs();
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed st=%0d pc=%0d rec=%h, expected st=%0d pc=%0d rec=%h",
                    tag, o.st, o.pc, o, e.st, e.pc, e);
    endtask

    // Check the current cycle, then advance to the next sampling point.
    task automatic cyc(input string tag, input obs_t e);
        chk(tag, e);
        @(negedge CLK);
    endtask

    // Hold RST for n edges (checking the cleared state after each), then
    // release; returns positioned on the first FETCH cycle.
    task automatic do_reset(input int n);
        RST = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("reset", '0);
        end
        RST  = 1'b0;
        m_pc = '0;
        m_ir = '0;
        @(negedge CLK);
    endtask

    // One full instruction: FETCH, DECODE, execute step(s).
    task automatic run_instr();
        obs_t e;
        cyc("fetch", rec(4'd1));
        m_ir = im[m_pc];
        m_pc = m_pc + 7'd1;
        cyc("decode", rec(4'd2));
        case (m_ir[15:12])
            4'h1: begin
                e = rec(4'd6); e.daddr = m_ir[11:4]; e.ra = m_ir[3:0]; e.dwr = 1'b1;
                cyc("store", e);
            end
            4'h2: begin
                e = rec(4'd4); e.daddr = m_ir[11:4]; e.rfs = 2'd1; e.wa = m_ir[3:0];
                cyc("load_a", e);
                e.st = 4'd5; e.wwr = 1'b1;
                cyc("load_b", e);
            end
            4'h3, 4'h4: begin
                e = rec(m_ir[15:12] == 4'h3 ? 4'd7 : 4'd8);
                e.ra = m_ir[11:8]; e.rb = m_ir[7:4]; e.wa = m_ir[3:0];
                e.alu = (m_ir[15:12] == 4'h3) ? 3'd1 : 3'd2;
                e.wwr = 1'b1;
                cyc("alu", e);
            end
            4'h5: cyc("halt", rec(4'd9));
`ifdef CU_LDI_EN
            4'h6: begin
                e = rec(4'd10); e.imm = m_ir[11:4]; e.rfs = 2'd2; e.wa = m_ir[3:0]; e.wwr = 1'b1;
                cyc("ldi", e);
            end
`endif
            default: cyc("noop", rec(4'd3));
        endcase
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) cyc("halt_hold", rec(4'd9));
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 128; i++) im[i] = 16'h0000;

        // Directed program: NOOP, ADD, LOAD, STORE, HALT.
        im[1] = 16'h3125;
        im[2] = 16'h20A3;
        im[3] = 16'h1FF7;
        im[4] = 16'h5000;
        do_reset(2);
        for (int i = 0; i < 5; i++) run_instr();
        halt_hold(6);

        // Reset arriving in LOAD_A must abort before LOAD_B's write.
        im[0] = 16'h20A3;
        do_reset(2);
        cyc("fetch", rec(4'd1));
        m_ir = im[m_pc];
        m_pc = m_pc + 7'd1;
        cyc("decode", rec(4'd2));
        begin
            obs_t e;
            e = rec(4'd4); e.daddr = 8'h0A; e.rfs = 2'd1; e.wa = 4'd3;
            chk("load_a_pre_rst", e);
        end
        do_reset(1);

        // Randomized program long enough to wrap PC, ending in HALT.
        for (int i = 0; i < 128; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'h5) w[15:12] = 4'h0;
            im[i] = w;
        end
        im[3] = 16'h6AB4;
        im[5] = 16'h0000;
        do_reset(1);
        for (int i = 0; i < 180; i++) run_instr();
        im[m_pc] = 16'h5000;
        run_instr();
        halt_hold(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
